// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// The input is double-flopped, the start bit is qualified at its midpoint and
// every later bit is sampled one bit period after the previous sample.
// Each frame produces one pulse: valid for a good stop bit, or frame_err for a
// low stop bit. A low stop bit also parks the receiver in BREAK until the line
// goes idle again.
module uart_rx #(
  parameter int BAUDRATE = 9600,
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CPB   = CLK_FREQ / BAUDRATE;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  // Fewer than four clocks per bit leaves no usable midpoint for sampling.
  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx: CLK_FREQ/BAUDRATE must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       data_n;
  logic             valid_n;
  logic             frame_err_n;
  logic             rx_meta;
  logic             rx_s;

  // Two-flop synchronizer; both stages reset to the idle line level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and output pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
    end
  end

  // Next-state logic: sample at the middle of each bit, decide on the stop bit.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    data_n      = data;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end

      START: begin
        if (cnt == CNT_MID) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            // Leaving at mid stop bit lets a back-to-back start edge be seen.
            data_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = BREAK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a scoreboard of expected pulses.
module tb_uart_rx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUDRATE = 100000;
  localparam int CPB      = CLK_FREQ / BAUDRATE;
  localparam int HALF     = CPB / 2;
  // Negedge that drives the start bit to the negedge where the pulse is seen:
  // two synchronizer edges, one IDLE->START edge, then HALF+9*CPB.
  localparam int LAT      = 3 + HALF + 9 * CPB;

  logic       clk  = 1'b0;
  logic       rstn = 1'b1;
  logic       rx   = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         t;
  } exp_t;

  exp_t q[$];
  exp_t e;

  uart_rx #(
    .BAUDRATE(BAUDRATE),
    .CLK_FREQ(CLK_FREQ)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drives one 8N1 frame starting at the current negedge; ends on a negedge
  // with rx left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                            input bit exp_err, input logic [7:0] exp_d);
    exp_t x;
    x.is_err = exp_err;
    x.d      = exp_d;
    x.t      = cyc + LAT;
    q.push_back(x);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  // Scoreboard: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn && (valid || frame_err)) begin
      chk("pulse_exclusive", {31'd0, valid & frame_err}, 32'd0);
      checks++;
      assert (q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_pulse observed valid=%0b frame_err=%0b data=%0h at cycle %0d expected no pulse",
               valid, frame_err, data, cyc);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pulse_kind_frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
        chk("pulse_data", {24'd0, data}, {24'd0, e.d});
        checks++;
        assert (cyc >= e.t - 2 && cyc <= e.t + 2) else begin
          failures++;
          $error("FAIL pulse_time observed cycle=%0d expected cycle=%0d (+/-2)", cyc, e.t);
        end
      end
    end
  end

  initial begin
    int busy_cnt;

    // Reset state, checked without any clock edge involvement.
    #3 rstn = 1'b0;
    #1;
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte.
    send_frame(8'h72, 1'b1, 1'b0, 8'h72);
    chk("single_busy_after", {31'd0, busy}, 32'd0);
    chk("single_data_hold", {24'd0, data}, 32'h72);
    repeat (10) @(negedge clk);

    // Back-to-back frames, no idle gap; 100-cycle spacing checked via timing.
    send_frame(8'h6F, 1'b1, 1'b0, 8'h6F);
    send_frame(8'h00, 1'b1, 1'b0, 8'h00);
    send_frame(8'h14, 1'b1, 1'b0, 8'h14);
    repeat (10) @(negedge clk);
    chk("b2b_all_seen", q.size(), 32'd0);

    // Glitch: three low cycles must not start a frame.
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) rx = 1'b1;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    checks++;
    assert (busy_cnt >= 1 && busy_cnt <= HALF + 1) else begin
      failures++;
      $error("FAIL glitch_busy_cycles observed=%0d expected 1..%0d", busy_cnt, HALF + 1);
    end
    chk("glitch_idle_after", {31'd0, busy}, 32'd0);
    chk("glitch_data_kept", {24'd0, data}, 32'h14);

    // Framing error followed by a held break.
    send_frame(8'hA5, 1'b1, 1'b0, 8'hA5);
    send_frame(8'h55, 1'b0, 1'b1, 8'hA5);
    repeat (40) @(negedge clk);
    chk("break_busy_held", {31'd0, busy}, 32'd1);
    chk("break_data_kept", {24'd0, data}, 32'hA5);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("break_released", {31'd0, busy}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 8'h3C);
    repeat (10) @(negedge clk);

    // Reset during data bit 4 of 0xFF: aborts with no pulse.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + 5) @(negedge clk);
    chk("midframe_busy_before_reset", {31'd0, busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("midframe_reset_data", {24'd0, data}, 32'd0);
    chk("midframe_reset_valid", {31'd0, valid}, 32'd0);
    chk("midframe_reset_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b0, 8'hC3);
    repeat (10) @(negedge clk);

    // Boundary bytes.
    send_frame(8'h00, 1'b1, 1'b0, 8'h00);
    chk("boundary_00_busy", {31'd0, busy}, 32'd0);
    send_frame(8'hFF, 1'b1, 1'b0, 8'hFF);
    repeat (20) @(negedge clk);
    chk("boundary_ff_data", {24'd0, data}, 32'hFF);

    chk("scoreboard_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
